keyframe_serializer: RTL and testbench

KEYFRAME_SERIALIZER -- requirements
Module: keyframe_serializer

---
 rtl/keyframe_pkg.sv | 18 +
 rtl/keyframe_serializer.sv | 133 +++++++++++++
 tb/tb_keyframe_serializer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/keyframe_pkg.sv
// Shared definitions for the keyframe serializer and the keyframe store writer:
// field widths, the warm-up length and the serializer state encoding.
package keyframe_pkg;

   localparam int KEY_W       = 64;
   localparam int FRAME_W     = 22;
   localparam int KEYFRAME_W  = KEY_W + FRAME_W;
   localparam int WARM_CYCLES = 100;

   typedef enum logic [2:0] {
      IDLE,
      KEY,
      FRAME,
      WARM,
      DONE
   } state_t;

endpackage

// File: rtl/keyframe_serializer.sv
// Serializes a snapshot of {frame, key} LSB first into a downstream LFSR loader
// under a valid/ready handshake, then pulses done.
// Optional warm-up: define KEYFRAME_SERIALIZER_WARMUP_EN to add a WARM state that
// strobes mix_valid for WARM_CYCLES cycles after the last bit; otherwise mix_valid
// is tied low and FRAME goes straight to DONE.
module keyframe_serializer #(
   parameter int KEY_W       = keyframe_pkg::KEY_W,
   parameter int FRAME_W     = keyframe_pkg::FRAME_W,
   parameter int WARM_CYCLES = keyframe_pkg::WARM_CYCLES
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [KEY_W+FRAME_W-1:0]   keyframe_in,
   input  logic                       bit_ready,
   output logic                       bit_out,
   output logic                       bit_valid,
   output logic                       frame_phase,
   output logic                       mix_valid,
   output logic                       busy,
   output logic                       done
);

   import keyframe_pkg::*;

   localparam int KF_W   = KEY_W + FRAME_W;
   // The counter covers both the bit index and the warm-up length, so it never wraps.
   localparam int CNT_W  = $clog2((KF_W > WARM_CYCLES) ? KF_W : WARM_CYCLES);
   localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(KF_W - 1);
`ifdef KEYFRAME_SERIALIZER_WARMUP_EN
   localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARM_CYCLES - 1);
`endif

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [KF_W-1:0]  shreg;
   logic [KF_W-1:0]  shreg_shifted;

   // The current bit is always the LSB of the snapshot; it only moves on a transfer.
   assign bit_out       = shreg[0];
   assign shreg_shifted = {1'b0, shreg[KF_W-1:1]};

`ifndef KEYFRAME_SERIALIZER_WARMUP_EN
   assign mix_valid = 1'b0;
`endif

   // Sequencer: state, bit counter, shift register and all registered flags.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge only; the shift register is an
      // ordinary register (not a memory), so it is cleared here as well.
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         shreg       <= '0;
         bit_valid   <= 1'b0;
         frame_phase <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef KEYFRAME_SERIALIZER_WARMUP_EN
         mix_valid   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads the
         // pre-edge values of state, cnt and shreg.
         case (state)
            IDLE: begin
               if (start) begin
                  shreg     <= keyframe_in;
                  cnt       <= '0;
                  bit_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= KEY;
               end
            end

            KEY: begin
               if (bit_ready) begin
                  shreg <= shreg_shifted;
                  cnt   <= cnt + CNT_W'(1);
                  if (cnt == KEY_LAST) begin
                     frame_phase <= 1'b1;
                     state       <= FRAME;
                  end
               end
            end

            FRAME: begin
               if (bit_ready) begin
                  shreg <= shreg_shifted;
                  if (cnt == FRAME_LAST) begin
                     bit_valid   <= 1'b0;
                     frame_phase <= 1'b0;
`ifdef KEYFRAME_SERIALIZER_WARMUP_EN
                     cnt         <= '0;
                     mix_valid   <= 1'b1;
                     state       <= WARM;
`else
                     done        <= 1'b1;
                     state       <= DONE;
`endif
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end

`ifdef KEYFRAME_SERIALIZER_WARMUP_EN
            WARM: begin
               if (cnt == WARM_LAST) begin
                  mix_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
`endif

            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keyframe_serializer.sv
// Self-checking bench for keyframe_serializer: table of full-sequence scenarios
// plus hand-written reset and start/reset-collision sequences.
module tb_keyframe_serializer;

   import keyframe_pkg::*;

`ifdef KEYFRAME_SERIALIZER_WARMUP_EN
   localparam int WARM_EXTRA = WARM_CYCLES;
`else
   localparam int WARM_EXTRA = 0;
`endif

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start;
   logic [KEYFRAME_W-1:0] keyframe_in;
   logic                  bit_ready;
   logic                  bit_out;
   logic                  bit_valid;
   logic                  frame_phase;
   logic                  mix_valid;
   logic                  busy;
   logic                  done;

   int errors = 0;
   int checks = 0;

   keyframe_serializer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .keyframe_in (keyframe_in),
      .bit_ready   (bit_ready),
      .bit_out     (bit_out),
      .bit_valid   (bit_valid),
      .frame_phase (frame_phase),
      .mix_valid   (mix_valid),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_bit_out"},     32'(bit_out),     32'd0);
      check({tag, "_bit_valid"},   32'(bit_valid),   32'd0);
      check({tag, "_frame_phase"}, 32'(frame_phase), 32'd0);
      check({tag, "_mix_valid"},   32'(mix_valid),   32'd0);
      check({tag, "_busy"},        32'(busy),        32'd0);
      check({tag, "_done"},        32'(done),        32'd0);
   endtask

   typedef struct {
      logic [KEYFRAME_W-1:0] kf;
      bit                    toggle;    // bit_ready = 1 on odd cycles, 0 on even
      bit                    inject;    // re-assert start mid-KEY and in DONE
      int                    exp_done;  // cycle of the done pulse, start cycle = 0
   } vec_t;

   vec_t vecs[4];

   // Full sequence: start in cycle 0, inputs driven and outputs sampled at negedge.
   task automatic run_vec(input vec_t v, input int n);
      int   idx        = 0;
      int   done_at    = -1;
      int   mix_cnt    = 0;
      logic busy_at_done = 1'b0;
      logic prev_bit   = 1'b0;
      bit   prev_stall = 1'b0;
      logic [KEYFRAME_W-1:0] other = ~v.kf;
      string tag = $sformatf("v%0d", n);

      @(negedge clk);
      start       = 1'b1;
      keyframe_in = v.kf;
      bit_ready   = 1'b1;
      for (int c = 1; c <= 400 && done_at < 0; c++) begin
         @(negedge clk);
         start       = 1'b0;
         keyframe_in = other;
         bit_ready   = v.toggle ? ((c % 2) == 1) : 1'b1;
         if (v.inject && c == 10) start = 1'b1;
         if (bit_valid) begin
            if (prev_stall) check({tag, "_stall_hold"}, 32'(bit_out), 32'(prev_bit));
            if (bit_ready) begin
               check($sformatf("%s_bit%0d", tag, idx), 32'(bit_out),
                     (idx < KEYFRAME_W) ? 32'(v.kf[idx]) : 32'hDEAD);
               check($sformatf("%s_phase%0d", tag, idx), 32'(frame_phase), 32'(idx >= KEY_W));
               idx++;
            end
            prev_stall = !bit_ready;
            prev_bit   = bit_out;
         end
         if (mix_valid) begin
            mix_cnt++;
            check({tag, "_warm_no_valid"}, 32'(bit_valid), 32'd0);
         end
         if (done) begin
            done_at      = c;
            busy_at_done = busy;
            check({tag, "_done_no_valid"}, 32'(bit_valid), 32'd0);
            if (v.inject) start = 1'b1;
         end
      end
      check({tag, "_done_cycle"}, 32'(done_at), 32'(v.exp_done));
      check({tag, "_transfers"},  32'(idx),     32'(KEYFRAME_W));
      check({tag, "_mix_cycles"}, 32'(mix_cnt), 32'(WARM_EXTRA));
      check({tag, "_busy_in_done"}, 32'(busy_at_done), 32'd1);
      @(negedge clk);
      start = 1'b0;
      check({tag, "_idle_after_done"}, 32'(busy), 32'd0);
      check({tag, "_done_one_cycle"},  32'(done), 32'd0);
   endtask

   initial begin
      logic [KEYFRAME_W-1:0] kf_a;
      logic [KEYFRAME_W-1:0] kf_b;
      int done_seen;

      kf_a = {22'h2AAAAA, 64'h0123456789ABCDEF};
      kf_b = {22'h3FFFFF, 64'h0};
      vecs[0] = '{kf: kf_a, toggle: 1'b0, inject: 1'b0, exp_done: 87  + WARM_EXTRA};
      vecs[1] = '{kf: kf_a, toggle: 1'b1, inject: 1'b0, exp_done: 172 + WARM_EXTRA};
      vecs[2] = '{kf: kf_a, toggle: 1'b0, inject: 1'b1, exp_done: 87  + WARM_EXTRA};
      vecs[3] = '{kf: kf_b, toggle: 1'b1, inject: 1'b1, exp_done: 172 + WARM_EXTRA};

      reset       = 1'b1;
      start       = 1'b0;
      bit_ready   = 1'b0;
      keyframe_in = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

      // Reset after 30 transfers: outputs clear next cycle and no done follows.
      @(negedge clk);
      start       = 1'b1;
      keyframe_in = kf_a;
      bit_ready   = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("midreset_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("midreset");
      reset     = 1'b0;
      done_seen = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("midreset_no_done", 32'(done_seen), 32'd0);
      run_vec(vecs[0], 4);

      // Reset and start together in IDLE: reset wins, nothing captured.
      @(negedge clk);
      reset       = 1'b1;
      start       = 1'b1;
      keyframe_in = kf_b;
      @(negedge clk);
      check("collide_busy", 32'(busy), 32'd0);
      check("collide_valid", 32'(bit_valid), 32'd0);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("collide_stays_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
